eth_rx_fcs_check: RTL and testbench
===================================

# eth_rx_fcs_check

Receive-side counterpart of the transmit CRC32 generator. It takes a raw GMII-style byte stream (preamble and SFD included) and strips and validates the preamble/SFD. It runs the same 8-bit-parallel Ethernet CRC32 over the frame, removes the 4-byte FCS through a delay line, and reports a per-frame good/bad verdict with saturating statistics. It sits between the PHY receive interface and the packet parser.

## Interface
Parameters:
- MIN_FRAME, 64: minimum legal frame length in bytes after the SFD, FCS included.
- MAX_FRAME, 1518: maximum legal frame length in bytes after the SFD, FCS included.
- CNT_W, 16: width of the good and bad frame counters.

Ports:
- clk  in  1  sole clock.
- clear  in  1  reset, synchronous and active-high.
- rx_data  in  8  received byte.
- rx_dv  in  1  data valid; high for the whole frame, preamble included.
- rx_er  in  1  PHY error, sampled only while rx_dv is high.
- out_data  out  8  payload byte (FCS removed).
- out_valid  out  1  out_data is valid this cycle.
- frame_done  out  1  one-cycle pulse at the end of every frame that reached DATA.
- frame_ok  out  1  verdict; valid only while frame_done is high.
- good_count  out  CNT_W  saturating count of good frames.
- bad_count  out  CNT_W  saturating count of bad frames.

## Operation
- State machine has four states: IDLE, PREAMBLE, DATA, DROP.
- Reset (clear) puts the block in DROP and zeroes every output and counter.
  - DROP exists so a frame already in progress when clear deasserts is never parsed mid-stream.
- DROP: stay while rx_dv=1; move to IDLE on rx_dv=0. No outputs are produced.
- IDLE: on a byte with rx_dv=1, go to PREAMBLE with the preamble index set to 1.
  - That first byte must be 8'h55; otherwise go to DROP.
- PREAMBLE:
  - Bytes at index 1..6 must be 8'h55.
  - The byte at index 7 must be 8'hD5 (SFD). On a match, go to DATA with the CRC register loaded to 32'hFFFFFFFF and the length counter cleared.
  - Any mismatch goes to DROP.
  - rx_dv=0 returns to IDLE. In none of these cases is frame_done raised or either counter changed.
- DATA, each byte with rx_dv=1:
  - CRC register takes the next-state value, computed on the bit-reversed byte.
  - Length counter increments (11 bits, saturating at 2047).
  - The byte shifts into a 4-deep delay line. If the line was already full, the oldest byte goes out on out_data with out_valid=1.
  - rx_er=1 sets a sticky error flag.
- DATA, rx_dv=0 (end of frame):
  - frame_ok = (CRC register == 32'hC704DD7B) && (MIN_FRAME <= length <= MAX_FRAME) && !error flag.
  - Raise frame_done, increment good_count or bad_count (saturating at all-ones), flush the delay line (those 4 bytes are the FCS and are discarded), go to IDLE.
- Frames shorter than 4 bytes emit no payload and are flagged bad.
- Over-length frames are forwarded in full and flagged bad.
- Payload out_valid is not retracted when a frame later fails the check; downstream must use frame_done/frame_ok to decide.

## Timing
- Payload latency: byte k sampled at edge t appears on out_data/out_valid after edge t+4 (because byte k+4 is sampled at edge t+4). rx_dv is contiguous within a frame.
- frame_done/frame_ok are registered: asserted for exactly one cycle after the edge that samples rx_dv=0.
- Back-to-back frames with a 1-cycle rx_dv gap are supported.
  - The IDLE byte that starts the next frame can coincide with frame_done.
- clear has priority over every other event, including mid-frame.
  - The interrupted frame produces no frame_done and no counter change.

## Structure
- Shared package eth_pkg holds:
  - ETH_PREAMBLE_BYTE (8'h55), ETH_SFD (8'hD5), ETH_HDR_LEN (8), ETH_CRC_INIT (32'hFFFFFFFF), ETH_CRC_RESIDUE (32'hC704DD7B);
  - the rx state enum.
- One sub-module, crc32_d8_step: purely combinational. It takes the current 32-bit CRC and an 8-bit byte and produces the next CRC, using the same polynomial and bit order as the transmitter, with byte reversal done inside.
  - The TX block shall be migrated to crc32_d8_step later.

## Test plan
- Minimum 64-byte frame (60 payload bytes plus correct FCS), preceded by 7×55 and D5 -> 60 bytes on out_data in order, frame_done=1, frame_ok=1, good_count=1.
- Same frame with one payload bit flipped -> frame_done=1, frame_ok=0, bad_count=1, all 60 bytes still emitted.
- 63-byte frame with valid FCS -> frame_ok=0. A 1519-byte frame -> frame_ok=0. A 1518-byte frame -> frame_ok=1.
- SFD replaced by 8'hD4 -> no out_valid, no frame_done, counters unchanged. The next good frame is accepted.
- rx_er pulsed for one byte mid-payload in an otherwise good frame -> frame_ok=0.
- clear asserted for one cycle at payload byte 20, with rx_dv held high for the rest of the frame -> no outputs and no frame_done for that frame. A following good frame after a 1-cycle gap gives frame_ok=1 and good_count=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: framing constants, CRC32 parameters,
// receive FSM state encoding and a byte bit-reversal helper.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD           = 8'hD5;
  localparam int unsigned ETH_HDR_LEN       = 8;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] ETH_CRC_POLY      = 32'h04C1_1DB7;
  localparam int unsigned ETH_FCS_LEN       = 4;
  localparam int unsigned ETH_LEN_W         = 11;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA,
    RX_DROP
  } rx_state_e;

  // Ethernet sends bits LSB first; the MSB-first CRC register wants them mirrored
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8_step.sv
// One byte step of the Ethernet CRC32 (MSB-first register, poly 04C11DB7).
// Purely combinational; the input byte is bit-reversed internally.
module crc32_d8_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [7:0]  data_rev;
  logic [31:0] crc_w;
  logic        fb;

  always_comb begin
    data_rev = bit_rev8(data_i);
    crc_w    = crc_i;
    fb       = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb    = crc_w[31] ^ data_rev[i];
      crc_w = {crc_w[30:0], 1'b0} ^ (fb ? ETH_CRC_POLY : 32'h0);
    end
    crc_o = crc_w;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive-side preamble/SFD strip, CRC32 validation and FCS removal with
// per-frame verdict and saturating good/bad frame statistics.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_dv_i,
  input  logic             rx_er_i,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  output logic             frame_done_o,
  output logic             frame_ok_o,
  output logic [CNT_W-1:0] good_count_o,
  output logic [CNT_W-1:0] bad_count_o
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned DLC_W    = 3;
  localparam int unsigned DL_DEPTH = ETH_FCS_LEN;

  localparam logic [ETH_LEN_W-1:0] LEN_SAT = '1;
  localparam logic [CNT_W-1:0]     CNT_SAT = '1;
  localparam logic [IDX_W-1:0]     SFD_IDX = IDX_W'(ETH_HDR_LEN - 1);
  localparam logic [DLC_W-1:0]     DL_FULL = DLC_W'(DL_DEPTH);

  rx_state_e                    state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [31:0]                  crc_q, crc_d;
  logic [ETH_LEN_W-1:0]         len_q, len_d;
  logic                         err_q, err_d;
  logic [DL_DEPTH-1:0][7:0]     dl_q, dl_d;
  logic [DLC_W-1:0]             dl_cnt_q, dl_cnt_d;
  logic [7:0]                   out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         done_q, done_d;
  logic                         ok_q, ok_d;
  logic [CNT_W-1:0]             good_q, good_d;
  logic [CNT_W-1:0]             bad_q, bad_d;

  logic [31:0] crc_next;
  logic        len_ok;
  logic        verdict;

  crc32_d8_step u_crc (
    .crc_i  (crc_q),
    .data_i (rx_data_i),
    .crc_o  (crc_next)
  );

  assign len_ok  = (32'(len_q) >= MIN_FRAME) && (32'(len_q) <= MAX_FRAME);
  assign verdict = (crc_q == ETH_CRC_RESIDUE) && len_ok && !err_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    crc_d       = crc_q;
    len_d       = len_q;
    err_d       = err_q;
    dl_d        = dl_q;
    dl_cnt_d    = dl_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    good_d      = good_q;
    bad_d       = bad_q;

    case (state_q)
      RX_DROP: begin
        if (!rx_dv_i) state_d = RX_IDLE;
      end

      RX_IDLE: begin
        if (rx_dv_i) begin
          if (rx_data_i == ETH_PREAMBLE_BYTE) begin
            state_d = RX_PREAMBLE;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = RX_DROP;
          end
        end
      end

      RX_PREAMBLE: begin
        if (!rx_dv_i) begin
          state_d = RX_IDLE;
        end else if (idx_q == SFD_IDX) begin
          if (rx_data_i == ETH_SFD) begin
            state_d  = RX_DATA;
            crc_d    = ETH_CRC_INIT;
            len_d    = '0;
            err_d    = 1'b0;
            dl_cnt_d = '0;
          end else begin
            state_d = RX_DROP;
          end
        end else if (rx_data_i == ETH_PREAMBLE_BYTE) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = RX_DROP;
        end
      end

      RX_DATA: begin
        if (rx_dv_i) begin
          crc_d = crc_next;
          if (len_q != LEN_SAT) len_d = len_q + ETH_LEN_W'(1);
          if (rx_er_i) err_d = 1'b1;
          // Last four bytes held back so the FCS never reaches the output
          dl_d = {dl_q[DL_DEPTH-2:0], rx_data_i};
          if (dl_cnt_q == DL_FULL) begin
            out_data_d  = dl_q[DL_DEPTH-1];
            out_valid_d = 1'b1;
          end else begin
            dl_cnt_d = dl_cnt_q + DLC_W'(1);
          end
        end else begin
          done_d   = 1'b1;
          ok_d     = verdict;
          dl_cnt_d = '0;
          state_d  = RX_IDLE;
          if (verdict) begin
            if (good_q != CNT_SAT) good_d = good_q + CNT_W'(1);
          end else begin
            if (bad_q != CNT_SAT) bad_d = bad_q + CNT_W'(1);
          end
        end
      end

      default: state_d = RX_DROP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q     <= RX_DROP;
      idx_q       <= '0;
      crc_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      dl_q        <= '0;
      dl_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      err_q       <= err_d;
      dl_q        <= dl_d;
      dl_cnt_q    <= dl_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign frame_done_o = done_q;
  assign frame_ok_o   = ok_q;
  assign good_count_o = good_q;
  assign bad_count_o  = bad_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frames built with a reflected CRC32
// reference, payload and verdict checked with immediate assertions.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        clear;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        frame_done_o;
  logic        frame_ok_o;
  logic [15:0] good_count_o;
  logic [15:0] bad_count_o;

  always #5 clk = ~clk;

  eth_rx_fcs_check dut (
    .clk_i        (clk),
    .clear_i      (clear),
    .rx_data_i    (rx_data),
    .rx_dv_i      (rx_dv),
    .rx_er_i      (rx_er),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .frame_done_o (frame_done_o),
    .frame_ok_o   (frame_ok_o),
    .good_count_o (good_count_o),
    .bad_count_o  (bad_count_o)
  );

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         first_cyc = 0;
  int         p0_cyc = 0;
  logic [7:0] got[$];
  logic [7:0] frm[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (out_valid_o) begin
      if (got.size() == 0) first_cyc = cyc;
      got.push_back(out_data_o);
    end
    if (frame_done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Payload bytes followed by FCS from an LSB-first reflected CRC32
  task automatic build(input int n_pay, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_pay; i++) begin
      b = 8'(i * 37 + seed);
      frm.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic clr);
    rx_dv   = dv;
    rx_data = d;
    rx_er   = er;
    clear   = clr;
    @(negedge clk);
  endtask

  // Returns on the negedge after the edge that samples rx_dv=0
  task automatic tx_frame(input logic [7:0] sfd, input int er_idx, input int clr_idx);
    got.delete();
    done_cnt = 0;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, sfd, 1'b0, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == 0) p0_cyc = cyc;
      if (i == clr_idx) begin
        got.delete();
        done_cnt = 0;
      end
      drive(1'b1, frm[i], i == er_idx, i == clr_idx);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_payload(input string tag);
    int n;
    int m;
    n = (frm.size() >= 4) ? frm.size() - 4 : 0;
    m = 0;
    for (int i = 0; i < n && i < got.size(); i++) if (got[i] === frm[i]) m++;
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    chk({tag, "_bytes"}, 32'(m), 32'(n));
  endtask

  task automatic chk_verdict(input string tag, input logic ok, input int good, input int bad);
    chk({tag, "_done"}, 32'(frame_done_o), 32'd1);
    chk({tag, "_ok"}, 32'(frame_ok_o), 32'(ok));
    chk({tag, "_good"}, 32'(good_count_o), 32'(good));
    chk({tag, "_bad"}, 32'(bad_count_o), 32'(bad));
    chk({tag, "_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    clear   = 1'b1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    rx_er   = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_ok", 32'(frame_ok_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    chk("rst_good", 32'(good_count_o), 32'd0);
    chk("rst_bad", 32'(bad_count_o), 32'd0);

    // Frame already running when clear drops must be ignored entirely
    got.delete();
    done_cnt = 0;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drop_done", 32'(done_cnt), 32'd0);
    chk("drop_out", 32'(got.size()), 32'd0);

    build(60, 3);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("min64", 1'b1, 1, 0);
    chk_payload("min64");
    chk("min64_latency", 32'(first_cyc - p0_cyc), 32'd5);

    build(60, 3);
    frm[10] = frm[10] ^ 8'h04;
    tx_frame(8'hD5, -1, -1);
    chk_verdict("bitflip", 1'b0, 1, 1);
    chk_payload("bitflip");

    build(59, 11);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("len63", 1'b0, 1, 2);
    chk_payload("len63");

    build(1514, 5);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("len1518", 1'b1, 2, 2);
    chk_payload("len1518");

    build(1515, 5);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("len1519", 1'b0, 2, 3);
    chk_payload("len1519");

    build(60, 7);
    tx_frame(8'hD4, -1, -1);
    chk("badsfd_done", 32'(frame_done_o), 32'd0);
    chk("badsfd_pulses", 32'(done_cnt), 32'd0);
    chk("badsfd_out", 32'(got.size()), 32'd0);
    chk("badsfd_good", 32'(good_count_o), 32'd2);
    chk("badsfd_bad", 32'(bad_count_o), 32'd3);

    build(60, 9);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("after_sfd", 1'b1, 3, 3);
    chk_payload("after_sfd");

    build(60, 13);
    tx_frame(8'hD5, 30, -1);
    chk_verdict("rx_er", 1'b0, 3, 4);

    build(60, 21);
    tx_frame(8'hD5, -1, 20);
    chk("clr_done", 32'(frame_done_o), 32'd0);
    chk("clr_pulses", 32'(done_cnt), 32'd0);
    chk("clr_out", 32'(got.size()), 32'd0);
    chk("clr_good", 32'(good_count_o), 32'd0);
    chk("clr_bad", 32'(bad_count_o), 32'd0);

    build(60, 3);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("post_clr", 1'b1, 1, 0);
    chk_payload("post_clr");

    frm.delete();
    frm.push_back(8'h12);
    frm.push_back(8'h34);
    tx_frame(8'hD5, -1, -1);
    chk_verdict("short2", 1'b0, 1, 1);
    chk("short2_out", 32'(got.size()), 32'd0);

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
